// File: rtl/axis_pkg.sv
// Shared types and constants for the two-input AXI-Stream multiplexer.
package axis_pkg;

  localparam int DATA_WIDTH = 8;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

  localparam logic PORT_1 = 1'b0;
  localparam logic PORT_2 = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } grant_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice (output register plus skid register) that fully
// registers the master side and the upstream ready.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH-1:0] skid_data, skid_data_next, out_data_next;
  logic                  skid_last, skid_last_next, out_last_next;
  logic                  skid_valid, skid_valid_next, out_valid_next;
  logic                  in_fire, drain;

  assign in_fire = in_valid && in_ready;
  assign drain   = out_valid && out_ready;

  // A new beat bypasses the skid register whenever the output slot frees up this cycle.
  always_comb begin
    out_data_next   = out_data;
    out_last_next   = out_last;
    out_valid_next  = out_valid;
    skid_data_next  = skid_data;
    skid_last_next  = skid_last;
    skid_valid_next = skid_valid;
    if (in_fire) begin
      if (!out_valid || drain) begin
        out_data_next  = in_data;
        out_last_next  = in_last;
        out_valid_next = 1'b1;
      end else begin
        skid_data_next  = in_data;
        skid_last_next  = in_last;
        skid_valid_next = 1'b1;
      end
    end else if (drain) begin
      if (skid_valid) begin
        out_data_next   = skid_data;
        out_last_next   = skid_last;
        skid_valid_next = 1'b0;
      end else begin
        out_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      out_data   <= out_data_next;
      out_last   <= out_last_next;
      out_valid  <= out_valid_next;
      skid_data  <= skid_data_next;
      skid_last  <= skid_last_next;
      skid_valid <= skid_valid_next;
      in_ready   <= !skid_valid_next;
    end
  end

endmodule

// File: rtl/mux_2_1.sv
// Two-input AXI-Stream mux: packet-atomic grant FSM and input mux feeding a
// registered skid buffer on the master port.
module mux_2_1
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = axis_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] s_data_1,
  input  logic                  s_valid_1,
  output logic                  s_ready_1,
  input  logic                  s_last_1,
  input  logic [DATA_WIDTH-1:0] s_data_2,
  input  logic                  s_valid_2,
  output logic                  s_ready_2,
  input  logic                  s_last_2,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  grant_state_t          state, state_next;
  logic                  locked_port, locked_port_next;
  logic                  grant;
  logic [DATA_WIDTH-1:0] mux_data;
  logic                  mux_valid, mux_last;
  logic                  buf_ready;
  logic                  accept;

  // The registered buffer ready is only ever exposed to the granted slave.
  always_comb begin
    grant = (state == LOCKED) ? locked_port : sel;
    if (grant == PORT_2) begin
      mux_data  = s_data_2;
      mux_valid = s_valid_2;
      mux_last  = s_last_2;
    end else begin
      mux_data  = s_data_1;
      mux_valid = s_valid_1;
      mux_last  = s_last_1;
    end
    s_ready_1 = buf_ready && (grant == PORT_1);
    s_ready_2 = buf_ready && (grant == PORT_2);
    accept    = mux_valid && buf_ready;
  end

  always_comb begin
    state_next       = state;
    locked_port_next = locked_port;
    if (accept) begin
      if (mux_last) begin
        state_next = IDLE;
      end else begin
        state_next       = LOCKED;
        locked_port_next = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      locked_port <= PORT_1;
    end else begin
      state       <= state_next;
      locked_port <= locked_port_next;
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  (mux_data),
    .in_last  (mux_last),
    .in_valid (mux_valid),
    .in_ready (buf_ready),
    .out_data (m_data),
    .out_last (m_last),
    .out_valid(m_valid),
    .out_ready(m_ready)
  );

endmodule

// File: tb/tb_mux_2_1.sv
// Directed bench for mux_2_1: vector table for grant/lock behaviour plus
// hand-written streaming, backpressure and reset-mid-packet sequences.
module tb_mux_2_1;
  import axis_pkg::*;

  logic       clk = 1'b0;
  logic       reset, sel;
  logic [7:0] s_data_1, s_data_2, m_data;
  logic       s_valid_1, s_ready_1, s_last_1;
  logic       s_valid_2, s_ready_2, s_last_2;
  logic       m_valid, m_ready, m_last;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic       sel;
    logic       v1;
    logic [7:0] d1;
    logic       l1;
    logic       v2;
    logic [7:0] d2;
    logic       l2;
    logic       mr;
    logic       e_mv;
    logic [7:0] e_md;
    logic       e_ml;
    logic       chk_data;
    logic       e_sr1;
    logic       e_sr2;
  } vec_t;

  vec_t  vecs [10];
  beat_t exp_q [$];
  bit    mr_pat [16];

  mux_2_1 #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .s_data_1 (s_data_1),
    .s_valid_1(s_valid_1),
    .s_ready_1(s_ready_1),
    .s_last_1 (s_last_1),
    .s_data_2 (s_data_2),
    .s_valid_2(s_valid_2),
    .s_ready_2(s_ready_2),
    .s_last_2 (s_last_2),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    else
      passed++;
  endtask

  task automatic applyStimulus(input vec_t v);
    sel       = v.sel;
    s_valid_1 = v.v1;
    s_data_1  = v.d1;
    s_last_1  = v.l1;
    s_valid_2 = v.v2;
    s_data_2  = v.d2;
    s_last_2  = v.l2;
    m_ready   = v.mr;
  endtask

  initial begin
    logic [7:0] stream [10];
    logic [7:0] byte_next, prev_data;
    logic       prev_last, fire_in, fire_out, stall;
    beat_t      b;

    // sel v1 d1 l1 v2 d2 l2 mr | e_mv e_md e_ml chk e_sr1 e_sr2
    vecs[0] = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'hA4, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 8'hA6, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 8'hC1, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 8'hC1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 8'hDD, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 8'hDD, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    mr_pat = '{1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 10; i++) stream[i] = 8'($urandom_range(0, 255));

    reset = 1'b1;
    applyStimulus(vecs[0]);
    step();
    step();
    checkOutput("reset_m_valid", 32'(m_valid), 0);
    checkOutput("reset_m_data", 32'(m_data), 0);
    checkOutput("reset_m_last", 32'(m_last), 0);
    checkOutput("reset_s_ready_1", 32'(s_ready_1), 0);
    checkOutput("reset_s_ready_2", 32'(s_ready_2), 0);
    reset = 1'b0;

    $display("[TB] vector table: release, packet lock, idle ready");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
      if (vecs[i].chk_data) begin
        checkOutput($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vecs[i].e_md));
        checkOutput($sformatf("vec%0d_m_last", i), 32'(m_last), 32'(vecs[i].e_ml));
      end
      checkOutput($sformatf("vec%0d_s_ready_1", i), 32'(s_ready_1), 32'(vecs[i].e_sr1));
      checkOutput($sformatf("vec%0d_s_ready_2", i), 32'(s_ready_2), 32'(vecs[i].e_sr2));
    end
    checkOutput("idle_no_leak", 32'(m_data != 8'hDD), 1);

    $display("[TB] streaming 10 bytes");
    sel       = 1'b0;
    m_ready   = 1'b1;
    s_valid_2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid_1 = 1'b1;
      s_data_1  = stream[i];
      s_last_1  = (i == 9);
      step();
      checkOutput($sformatf("stream%0d_valid", i), 32'(m_valid), 1);
      checkOutput($sformatf("stream%0d_data", i), 32'(m_data), 32'(stream[i]));
      checkOutput($sformatf("stream%0d_last", i), 32'(m_last), 32'(i == 9));
    end
    s_valid_1 = 1'b0;
    step();
    checkOutput("stream_idle_after", 32'(m_valid), 0);

    $display("[TB] backpressure");
    byte_next = 8'h40;
    for (int c = 0; c < 36; c++) begin
      sel       = 1'b0;
      s_last_1  = 1'b0;
      s_data_1  = byte_next;
      m_ready   = (c < 16) ? mr_pat[c] : 1'b1;
      s_valid_1 = (c < 16);
      fire_in   = s_valid_1 && s_ready_1;
      fire_out  = m_valid && m_ready;
      stall     = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (fire_out) begin
        if (exp_q.size() == 0) begin
          checkOutput("bp_unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          checkOutput("bp_data", 32'(m_data), 32'(b.data));
          checkOutput("bp_last", 32'(m_last), 32'(b.last));
        end
      end
      if (fire_in) begin
        exp_q.push_back('{data: byte_next, last: 1'b0});
        byte_next++;
      end
      step();
      if (stall) begin
        checkOutput("bp_stall_valid", 32'(m_valid), 1);
        checkOutput("bp_stall_data", 32'(m_data), 32'(prev_data));
        checkOutput("bp_stall_last", 32'(m_last), 32'(prev_last));
      end
      checkOutput("bp_occupancy", 32'(exp_q.size() <= 2), 1);
      checkOutput("bp_ready_vs_fill", 32'(s_ready_1), 32'(exp_q.size() < 2));
    end
    checkOutput("bp_all_drained", 32'(exp_q.size()), 0);
    checkOutput("bp_output_idle", 32'(m_valid), 0);

    // Close the still-open slave-1 packet so the grant returns to sel.
    s_valid_1 = 1'b1;
    s_data_1  = 8'h5F;
    s_last_1  = 1'b1;
    m_ready   = 1'b1;
    step();
    checkOutput("close_data", 32'(m_data), 32'h5F);
    checkOutput("close_last", 32'(m_last), 1);
    s_valid_1 = 1'b0;

    $display("[TB] reset mid-packet");
    sel       = 1'b1;
    s_valid_2 = 1'b1;
    s_data_2  = 8'hE1;
    s_last_2  = 1'b0;
    step();
    checkOutput("mid_e1_data", 32'(m_data), 32'hE1);
    s_data_2 = 8'hE2;
    step();
    checkOutput("mid_e2_data", 32'(m_data), 32'hE2);
    reset     = 1'b1;
    sel       = 1'b0;
    s_valid_1 = 1'b1;
    s_data_1  = 8'hF1;
    s_last_1  = 1'b1;
    s_data_2  = 8'hE3;
    step();
    checkOutput("mid_reset_m_valid", 32'(m_valid), 0);
    checkOutput("mid_reset_m_data", 32'(m_data), 0);
    checkOutput("mid_reset_s_ready_1", 32'(s_ready_1), 0);
    checkOutput("mid_reset_s_ready_2", 32'(s_ready_2), 0);
    reset = 1'b0;
    step();
    checkOutput("mid_release_s_ready_1", 32'(s_ready_1), 1);
    checkOutput("mid_release_s_ready_2", 32'(s_ready_2), 0);
    checkOutput("mid_release_m_valid", 32'(m_valid), 0);
    step();
    checkOutput("mid_f1_valid", 32'(m_valid), 1);
    checkOutput("mid_f1_data", 32'(m_data), 32'hF1);
    checkOutput("mid_f1_last", 32'(m_last), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux_2_1.md
# mux_2_1

Two-input AXI-Stream multiplexer with packet-atomic source selection and a registered, skid-buffered master port. `sel` chooses which slave stream is forwarded. The choice is locked for the duration of a packet, so beats from the two sources never interleave. It sits between two 8-bit byte-stream producers and a single downstream consumer, and decouples the consumer's `m_ready` timing from the producers.

## Interface
- `DATA_WIDTH`, default 8: width of all data buses.
- `clk`  in  1: single clock; everything samples on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `sel`  in  1: source select request; 0 selects slave 1, 1 selects slave 2.
- `s_data_1`  in  DATA_WIDTH: slave 1 data.
- `s_valid_1`  in  1: slave 1 valid.
- `s_ready_1`  out  1: slave 1 ready.
- `s_last_1`  in  1: slave 1 end-of-packet.
- `s_data_2`, `s_valid_2`, `s_ready_2`, `s_last_2`: same as slave 1, for slave 2.
- `m_data`  out  DATA_WIDTH: master data.
- `m_valid`  out  1: master valid.
- `m_ready`  in  1: master ready.
- `m_last`  out  1: master end-of-packet.

## Operation
- **Grant.** `grant = in_pkt ? locked_port : sel`.
  - `in_pkt` and `locked_port` are registers.
  - Only the granted slave can see ready high. The non-granted slave's `s_ready_x` is held at 0.
- **Accept.** A slave beat is accepted when `s_valid_k && s_ready_k`. The rules below are evaluated on the accepted beat:
  - `s_last_k = 0`: set `in_pkt = 1` and `locked_port = k`.
  - `s_last_k = 1`: clear `in_pkt`. The next beat uses `sel` again.
  - Single-beat packet (first beat has last = 1): `in_pkt` stays 0.
- **Changing `sel` mid-packet.**
  - The change is ignored until the TLAST beat of the current packet is accepted.
  - Switching then takes effect on the next cycle, with no idle bubble required.
- **Output path.** The output path is a two-entry register slice: an output register plus a skid register.
  - Accepted `{data, last}` goes to the output register if that register is empty or is being drained this cycle (`m_ready` high). Otherwise it goes to the skid register.
  - When the output register drains and the skid register is full, the skid contents move into the output register.
  - `s_ready_grant` is registered and equals `!skid_valid`.
- **Data integrity.** Data and last are forwarded unmodified and in order. Nothing is dropped or duplicated.
- **Invalid data.** Slave data is ignored while valid is low.
- **Reset.** These values are held while `reset` is high and take effect on the next edge:
  - `m_valid = 0`, `m_data = 0`, `m_last = 0`.
  - `s_ready_1 = s_ready_2 = 0`.
  - `in_pkt = 0`, `locked_port = 0`, skid empty.
  - Any in-flight beats and packet state are discarded, with no completion of a partial packet.

## Timing
- **Latency.** A beat accepted at edge N appears on `m_data` and `m_valid` after edge N, i.e. one cycle later.
- **Throughput.** One beat per cycle when `m_valid && m_ready` is sustained.
- **After reset.** The granted `s_ready` rises one cycle after `reset` deasserts.
- **AXI-Stream rules on the master port.** While `m_valid=1 && m_ready=0`, `m_data`, `m_last` and `m_valid` hold stable. `m_valid` never depends combinationally on `m_ready`.
- **Backpressure.**
  - `m_ready` low for 1 cycle while the output is full: at most one extra beat is absorbed (into the skid register). `s_ready` then drops.
  - `s_ready` returns high the cycle after the skid register empties.
- **Simultaneous events.**
  - Drain and accept in the same cycle with skid empty: the new beat goes straight to the output register.
  - `sel` toggling in the same cycle a TLAST beat is accepted: the new `sel` value governs the next beat.
- No combinational path from any `s_*` input to any `m_*` output.

## Structure
- **Shared package (`axis_pkg`).**
  - `DATA_WIDTH` default.
  - `typedef` for the beat `{data, last}`.
  - Port-index constants `PORT_1 = 0`, `PORT_2 = 1`.
- **Sub-module `axis_skid_buffer`.** Holds the output and skid registers and the ready logic. The top level holds the grant FSM (states IDLE/LOCKED) and the input mux.

## Test plan
- **Reset.** Hold reset 1 cycle, then release with `sel=0`, `s_valid_1=1`, `m_ready=1`.
  - All outputs are 0 during reset.
  - `s_ready_1=1`, `s_ready_2=0` the cycle after release.
  - The first `s_data_1` byte appears on `m_data` one cycle after acceptance.
- **Streaming.** `sel=0`, 10 random bytes, `m_ready=1` throughout: the 10 bytes appear in order, back-to-back, each with 1-cycle latency.
- **Backpressure.** `m_ready` pattern 1,0,0,1×5,0×4,1×4 while slave 1 streams continuously.
  - `m_data` is stable during every stall.
  - At most 1 beat is buffered per stall.
  - No loss: the output sequence equals the input sequence.
- **Packet lock.** Slave 1 sends 5 beats (last on beat 5), and `sel` goes 0→1 after beat 2.
  - All 5 slave-1 beats are forwarded.
  - `s_ready_2=0` until the beat-5 handshake.
  - A slave-2 beat is forwarded starting the next cycle.
- **Reset mid-packet.** Assert reset after beat 2 of a slave-2 packet: `m_valid=0`, `in_pkt` cleared, and `sel=0` is honoured immediately after release.
- **Idle ready.** `sel=1` with `s_valid_2=0` and `s_valid_1=1`: `m_valid` stays 0, `s_ready_1=0`, and no slave-1 data leaks to `m_data`.
